// File: rtl/id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_stage
//  Brief    : ID/EX pipeline register with a valid/ready handshake,
//             flush-to-bubble, an optional 2-entry skid buffer, and a
//             saturating stall-cycle counter for performance debug.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_stage #(
   parameter int                DATA_W     = 160,
   parameter int                SKID       = 1,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,        // active-high despite the name
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              stall_cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic              w_out_valid;
   logic [DATA_W-1:0] w_out_data;
   logic              w_in_ready;

   generate
      if (SKID != 0) begin : g_skid
         // M is the register facing execute; S catches the beat that
         // arrives in the cycle execute first pushes back.
         logic              r_m_valid;
         logic [DATA_W-1:0] r_m_data;
         logic              r_s_valid;
         logic [DATA_W-1:0] r_s_data;
         logic              r_in_ready;
         logic              w_in_xfer;
         logic              w_out_xfer;

         assign w_in_xfer  = in_valid & r_in_ready;
         assign w_out_xfer = r_m_valid & out_ready;

         // Main/skid register update; flush beats every other event.
         always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
               r_m_valid  <= 1'b0;
               r_m_data   <= BUBBLE_VAL;
               r_s_valid  <= 1'b0;
               r_s_data   <= BUBBLE_VAL;
               r_in_ready <= 1'b1;
            end else if (flush) begin
               r_m_valid  <= 1'b0;
               r_m_data   <= BUBBLE_VAL;
               r_s_valid  <= 1'b0;
               r_s_data   <= BUBBLE_VAL;
               r_in_ready <= 1'b1;
            end else if (w_out_xfer) begin
               if (r_s_valid) begin
                  // S is full so in_ready was low: no input beat can
                  // collide with the S->M move.
                  r_m_data   <= r_s_data;
                  r_s_valid  <= 1'b0;
                  r_in_ready <= 1'b1;
               end else if (w_in_xfer) begin
                  r_m_data <= in_data;
               end else begin
                  r_m_valid <= 1'b0;
               end
            end else if (w_in_xfer) begin
               if (!r_m_valid) begin
                  r_m_valid <= 1'b1;
                  r_m_data  <= in_data;
               end else begin
                  r_s_valid  <= 1'b1;
                  r_s_data   <= in_data;
                  r_in_ready <= 1'b0;
               end
            end
         end

         assign w_out_valid = r_m_valid;
         assign w_out_data  = r_m_data;
         assign w_in_ready  = r_in_ready;
      end else begin : g_noskid
         logic              r_valid;
         logic [DATA_W-1:0] r_data;
         logic              w_in_xfer;
         logic              w_out_xfer;

         assign w_in_ready = out_ready | ~r_valid;
         assign w_in_xfer  = in_valid & w_in_ready;
         assign w_out_xfer = r_valid & out_ready;

         // Single output register; data only loads on an accepted beat.
         always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
               r_valid <= 1'b0;
               r_data  <= BUBBLE_VAL;
            end else if (flush) begin
               r_valid <= 1'b0;
               r_data  <= BUBBLE_VAL;
            end else if (w_in_xfer) begin
               r_valid <= 1'b1;
               r_data  <= in_data;
            end else if (w_out_xfer) begin
               r_valid <= 1'b0;
            end
         end

         assign w_out_valid = r_valid;
         assign w_out_data  = r_data;
      end
   endgenerate

   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating count of cycles where execute holds off a valid beat.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_stall_cnt <= '0;
      end else if (stall_cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = w_out_data;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_pipe_stage
//  Brief    : Scoreboard bench for id_ex_pipe_stage, SKID=1 and SKID=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_stage;

   localparam logic [159:0] c_bubble_a = 160'h13;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic clr;

   logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [159:0] a_in_data, a_out_data;
   logic [3:0]   a_stall_cnt;

   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0]  b_in_data, b_out_data;
   logic [15:0]  b_stall_cnt;

   logic [159:0] a_q[$];
   logic [31:0]  b_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_pipe_stage #(.DATA_W(160), .SKID(1), .BUBBLE_VAL(c_bubble_a), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .flush(flush), .stall_cnt_clr(clr), .stall_cnt(a_stall_cnt)
   );

   id_ex_pipe_stage #(.DATA_W(32), .SKID(0), .BUBBLE_VAL(32'h0), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .flush(1'b0), .stall_cnt_clr(clr), .stall_cnt(b_stall_cnt)
   );

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor for the SKID=1 instance
   initial begin
      logic [159:0] exp;
      forever begin
         @(negedge clk);
         if (!rst_n && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL a_unexpected_beat: got %0h, required no beat", a_out_data);
            end else begin
               exp = a_q.pop_front();
               chk("a_scoreboard", a_out_data, exp);
            end
         end
      end
   end

   // Monitor for the SKID=0 instance
   initial begin
      logic [31:0] exp;
      forever begin
         @(negedge clk);
         if (!rst_n && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL b_unexpected_beat: got %0h, required no beat", b_out_data);
            end else begin
               exp = b_q.pop_front();
               chk("b_scoreboard", {128'h0, b_out_data}, {128'h0, exp});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; flush = 1'b0; clr = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      tick(); tick();
      chk("a_reset_out_valid", a_out_valid, 0);
      chk("a_reset_out_data", a_out_data, c_bubble_a);
      chk("a_reset_stall_cnt", a_stall_cnt, 0);
      chk("b_reset_out_valid", b_out_valid, 0);
      rst_n = 1'b0;
      chk("a_reset_in_ready", a_in_ready, 1);
      tick();

      // Streaming, 1-cycle latency
      a_out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 160'(i);
         a_q.push_back(160'(i));
         chk("a_stream_in_ready", a_in_ready, 1);
         tick();
         chk("a_stream_latency", a_out_data, 160'(i));
      end
      a_in_valid = 1'b0;
      tick();
      chk("a_stream_drained", a_out_valid, 0);

      // Backpressure fills M then S
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 160'hA; a_q.push_back(160'hA);
      chk("a_bp_ready_first", a_in_ready, 1);
      tick();
      a_in_data = 160'hB; a_q.push_back(160'hB);
      chk("a_bp_ready_second", a_in_ready, 1);
      tick();
      a_in_valid = 1'b0;
      chk("a_bp_ready_full", a_in_ready, 0);
      chk("a_bp_stall_1", a_stall_cnt, 1);
      repeat (3) tick();
      chk("a_bp_data_stable", a_out_data, 160'hA);
      chk("a_bp_stall_4", a_stall_cnt, 4);
      a_out_ready = 1'b1;
      tick();
      chk("a_bp_ready_back", a_in_ready, 1);
      chk("a_bp_skid_to_main", a_out_data, 160'hB);
      chk("a_bp_stall_held", a_stall_cnt, 4);
      tick();
      chk("a_bp_drained", a_out_valid, 0);

      // Flush with occupancy 2 and a beat offered in the same cycle
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 160'h21; a_q.push_back(160'h21);
      tick();
      a_in_data = 160'h22; a_q.push_back(160'h22);
      tick();
      chk("a_fl_full", a_in_ready, 0);
      flush = 1'b1; a_in_data = 160'hC;
      a_q.delete();
      tick();
      flush = 1'b0; a_in_valid = 1'b0;
      chk("a_fl_out_valid", a_out_valid, 0);
      chk("a_fl_bubble", a_out_data, c_bubble_a);
      chk("a_fl_in_ready", a_in_ready, 1);
      chk("a_fl_stall_kept", a_stall_cnt, 6);
      a_out_ready = 1'b1;
      repeat (2) tick();
      chk("a_fl_no_ghost", a_out_valid, 0);

      // Saturating counter, clear priority
      clr = 1'b1; tick(); clr = 1'b0;
      chk("a_cnt_cleared", a_stall_cnt, 0);
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 160'h33; a_q.push_back(160'h33);
      tick();
      a_in_valid = 1'b0;
      repeat (20) tick();
      chk("a_cnt_saturate", a_stall_cnt, 15);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("a_cnt_clr_in_stall", a_stall_cnt, 0);
      tick();
      chk("a_cnt_recount", a_stall_cnt, 1);
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;

      // Asynchronous reset with occupancy 2
      a_in_valid = 1'b1; a_in_data = 160'h41; a_q.push_back(160'h41);
      tick();
      a_in_data = 160'h42; a_q.push_back(160'h42);
      tick();
      a_in_valid = 1'b0;
      chk("a_rst_full", a_in_ready, 0);
      #2 rst_n = 1'b1;
      #1;
      a_q.delete();
      chk("a_rst_out_valid", a_out_valid, 0);
      chk("a_rst_bubble", a_out_data, c_bubble_a);
      chk("a_rst_stall", a_stall_cnt, 0);
      @(posedge clk); #1 rst_n = 1'b0;
      chk("a_rst_in_ready", a_in_ready, 1);
      chk("a_rst_idle", a_out_valid, 0);
      tick();

      // SKID=0: combinational in_ready
      b_out_ready = 1'b0;
      b_in_valid = 1'b1; b_in_data = 32'h4; b_q.push_back(32'h4);
      chk("b_empty_ready", b_in_ready, 1);
      tick();
      b_in_data = 32'h5;
      #1;
      chk("b_blocked_ready", b_in_ready, 0);
      b_out_ready = 1'b1;
      #1;
      chk("b_comb_ready", b_in_ready, 1);
      b_q.push_back(32'h5);
      tick();
      chk("b_next_beat", {128'h0, b_out_data}, 160'h5);
      b_in_valid = 1'b0; b_in_data = 'x;
      tick();
      chk("b_drained", b_out_valid, 0);
      chk("b_data_hold", {128'h0, b_out_data}, 160'h5);
      chk("b_stall_zero", b_stall_cnt, 0);

      repeat (3) tick();
      chk("a_queue_empty", a_q.size(), 0);
      chk("b_queue_empty", b_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
